mac_seq_ctrl: RTL
=================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 8, giving the operand digit width W in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: request present.
REQ-005 SHALL have port in_ready, output, 1 bit: controller can accept a request.
REQ-006 SHALL have port cfg, input, 2 bits: 2'b00 SINGLE, 2'b01 DUAL, 2'b10 QUAD, 2'b11 invalid.
REQ-007 SHALL have port a, input, 4W bits: digits A3..A0, with A0 in the LSBs.
REQ-008 SHALL have port b, input, 4W bits: digits B3..B0, with B0 in the LSBs.
REQ-009 SHALL have port mul_en, output, 1 bit: the shared multiplier is in use this cycle.
REQ-010 SHALL have port mul_a, output, W bits: A-digit driven to the shared multiplier.
REQ-011 SHALL have port mul_b, output, W bits: B-digit driven to the shared multiplier.
REQ-012 SHALL have port mul_c, input, 2W bits: unsigned product mul_a*mul_b, combinational, same cycle.
REQ-013 SHALL have port out_valid, output, 1 bit: result available.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have port out_data, output, 8W bits: result.
REQ-016 SHALL have port out_err, output, 1 bit: the request had an invalid cfg.

Function
REQ-017 SHALL use states IDLE, MUL and DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE with rst high; a request is accepted on an edge where in_valid&&in_ready.
REQ-019 SHALL, on accept, register a, b and cfg, clear the accumulator, and zero the step counter i (B index) and j (A index).
REQ-020 SHALL then go to MUL for a valid cfg, or straight to DONE with out_data=0 and out_err=1 for cfg 2'b11.
REQ-021 SHALL set digit count n = 1, 2 or 4 for SINGLE, DUAL or QUAD; operands are the unsigned values formed by digits n-1..0, and upper digits are ignored.
REQ-022 SHALL, in MUL, drive mul_en=1, mul_a=A_j and mul_b=B_i.
REQ-023 SHALL, in MUL, add mul_c shifted left by (i+j)*W into the 8W-bit accumulator on each edge.
REQ-024 SHALL step j fastest: increment j; at j=n-1 wrap j to 0 and increment i.
REQ-025 SHALL, after step (i=n-1, j=n-1), go to DONE; MUL lasts n*n cycles (1/4/16), and out_valid rises on the n*n-th edge after the accepting edge.
REQ-026 SHALL, in DONE, drive out_valid=1 and out_data=accumulator, with out_err=0 for a valid cfg.
REQ-027 SHALL hold out_data and out_err stable while out_valid&&!out_ready.
REQ-028 SHALL return to IDLE on out_valid&&out_ready; in_ready is 1 on the next cycle, so no overlap with the next request.
REQ-029 SHALL drive mul_en=0, mul_a=0 and mul_b=0 outside MUL.
REQ-030 SHALL ignore input changes on a, b and cfg after accept.
REQ-031 SHALL never overflow the accumulator, since the QUAD maximum product fits in 8W bits.

Reset
REQ-032 SHALL, while rst=0, force state IDLE, accumulator and counters 0, in_ready=0, out_valid=0, out_data=0, out_err=0 and mul_en=0, regardless of clk.
REQ-033 SHALL abandon any in-flight operation on reset with no result emitted, and in_ready=1 on the first cycle after rst rises.

Verification (W=8)
REQ-034 SHALL cover SINGLE with a[7:0]=0xFF and b[7:0]=0xFF -> exactly 1 mul_en cycle, then out_data=0xFE01 and out_err=0.
REQ-035 SHALL cover DUAL with a[15:0]=0x1234 and b[15:0]=0x5678 -> 4 mul_en cycles, mul_a/mul_b sequence (0x34,0x78),(0x12,0x78),(0x34,0x56),(0x12,0x56), then out_data=0x06260060.
REQ-036 SHALL cover QUAD with a=b=0xFFFFFFFF -> 16 mul_en cycles, then out_data=0xFFFFFFFE00000001.
REQ-037 SHALL cover cfg=2'b11 -> no mul_en, and out_valid on the edge after accept with out_data=0 and out_err=1.
REQ-038 SHALL cover out_ready held low 5 cycles in DONE -> out_data stable and in_ready=0 throughout, IDLE after out_ready=1.
REQ-039 SHALL cover rst asserted on the 7th MUL cycle of QUAD -> all outputs 0 immediately, no out_valid after release, and a new SINGLE request completing correctly.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Purpose: sequences a 4-digit schoolbook multiply through one shared W x W multiplier.
// Latency: out_valid rises n*n edges after accept (n = 1/2/4); an invalid cfg reaches DONE on the accept edge.
// Backpressure: result is held in DONE until out_ready; in_ready is low from accept until the result drains.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, cfg (00 single, 01 dual, 10 quad, 11 invalid), a/b (4 digits, digit 0 in LSBs)
//   mul_en/mul_a/mul_b -> external multiplier, mul_c <- its combinational product
//   out_valid/out_ready, out_data (8W-bit product), out_err (invalid cfg)
module mac_seq_ctrl #(
  parameter int MIN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             cfg,
  input  logic [4*MIN_WIDTH-1:0] a,
  input  logic [4*MIN_WIDTH-1:0] b,
  output logic                   mul_en,
  output logic [MIN_WIDTH-1:0]   mul_a,
  output logic [MIN_WIDTH-1:0]   mul_b,
  input  logic [2*MIN_WIDTH-1:0] mul_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*MIN_WIDTH-1:0] out_data,
  output logic                   out_err
);

  localparam int W = MIN_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [4*W-1:0]   a_r;
  logic [4*W-1:0]   b_r;
  logic [1:0]       nm1;   // digit count minus one
  logic [1:0]       i;     // B digit index (slow)
  logic [1:0]       j;     // A digit index (fast)
  logic [8*W-1:0]   acc;
  logic             err;
  logic [8*W-1:0]   prod_sh;

  // Product aligned to digit position i+j before accumulation.
  assign prod_sh = (8*W)'(mul_c) << ((32'(i) + 32'(j)) * W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      nm1   <= '0;
      i     <= '0;
      j     <= '0;
      acc   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            i   <= '0;
            j   <= '0;
            acc <= '0;
            case (cfg)
              2'b00:   nm1 <= 2'd0;
              2'b01:   nm1 <= 2'd1;
              default: nm1 <= 2'd3;
            endcase
            if (cfg == 2'b11) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= MUL;
            end
          end
        end
        MUL: begin
          acc <= acc + prod_sh;
          if (j == nm1) begin
            j <= '0;
            if (i == nm1) begin
              state <= DONE;
            end else begin
              i <= i + 2'd1;
            end
          end else begin
            j <= j + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst so it reads 0 while reset is held, independent of clk.
  assign in_ready  = rst && (state == IDLE);
  assign mul_en    = (state == MUL);
  assign mul_a     = mul_en ? W'(a_r >> (32'(j) * W)) : '0;
  assign mul_b     = mul_en ? W'(b_r >> (32'(i) * W)) : '0;
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? acc : '0;
  assign out_err   = out_valid ? err : 1'b0;

endmodule
